// File: rtl/serial_adder_rr_sched.sv
// serial_adder_rr_sched
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Each granted operation latches the requester's operand pair, adds it LSB
// first one bit per clock through a single full adder with a carry flop, then
// returns the sum and carry-out together with a per-requester ack.
//
// Optional build macro: SERIAL_SCHED_SATURATE_EN
//   defined   : on a final carry, out is clamped to all ones (cout still set)
//   undefined : out wraps modulo 2^WORDWIDTH
module serial_adder_rr_sched #(
    parameter int WORDWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WORDWIDTH-1:0] a_in,
    input  logic [NREQ*WORDWIDTH-1:0] b_in,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic [WORDWIDTH-1:0]      out,
    output logic                      cout,
    output logic                      done,
    output logic [IDW-1:0]            done_id,
    output logic                      busy
);

    localparam int                CNT_W    = $clog2(WORDWIDTH);
    localparam int                REXT_W   = 1 << IDW;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDWIDTH - 1);
    localparam logic [IDW-1:0]    ID_LAST  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder carry (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] oh;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (idx == IDW'(i));
        end
        return oh;
    endfunction

    // FSM and datapath state
    state_t                 state_q,   state_d;
    logic [IDW-1:0]         sel_q,     sel_d;
    logic [IDW-1:0]         last_q,    last_d;
    logic [WORDWIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WORDWIDTH-1:0]   b_sh_q,    b_sh_d;
    logic [WORDWIDTH-1:0]   sum_q,     sum_d;
    logic                   carry_q,   carry_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;

    // Registered outputs
    logic [NREQ-1:0]        gnt_q,     gnt_d;
    logic [NREQ-1:0]        ack_q,     ack_d;
    logic [WORDWIDTH-1:0]   out_q,     out_d;
    logic                   cout_q,    cout_d;
    logic                   done_q,    done_d;
    logic [IDW-1:0]         done_id_q, done_id_d;
    logic                   busy_q,    busy_d;

    // Combinational helpers
    logic [REXT_W-1:0]      req_ext_s;
    logic                   pick_vld_s;
    logic [IDW-1:0]         pick_s;
    logic [WORDWIDTH-1:0]   a_sel_s;
    logic [WORDWIDTH-1:0]   b_sel_s;
    logic                   s_bit_s;
    logic                   c_next_s;
    logic [WORDWIDTH-1:0]   sum_next_s;
    logic [WORDWIDTH-1:0]   result_s;

    // Zero-pad req so every IDW-bit index addresses a real bit.
    assign req_ext_s = REXT_W'(req);

    // Round-robin pick: first set request scanning from last+1 with wrap.
    always_comb begin
        logic [IDW-1:0] scan_v;
        logic           hit_v;
        pick_vld_s = 1'b0;
        pick_s     = '0;
        scan_v     = last_q;
        hit_v      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            scan_v     = (scan_v == ID_LAST) ? '0 : scan_v + 1'b1;
            hit_v      = !pick_vld_s && req_ext_s[scan_v];
            pick_s     = hit_v ? scan_v : pick_s;
            pick_vld_s = pick_vld_s | hit_v;
        end
    end

    // Operand slice mux for the selected requester.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel_s = a_sel_s | (a_in[i*WORDWIDTH +: WORDWIDTH] & {WORDWIDTH{sel_q == IDW'(i)}});
            b_sel_s = b_sel_s | (b_in[i*WORDWIDTH +: WORDWIDTH] & {WORDWIDTH{sel_q == IDW'(i)}});
        end
    end

    // One bit-serial adder step and the final (optionally saturated) result.
    always_comb begin
        s_bit_s    = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
        c_next_s   = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
        sum_next_s = {s_bit_s, sum_q[WORDWIDTH-1:1]};
`ifdef SERIAL_SCHED_SATURATE_EN
        result_s   = c_next_s ? {WORDWIDTH{1'b1}} : sum_next_s;
`else
        result_s   = sum_next_s;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = pick_vld_s ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = ST_ADD;
            ST_ADD:  state_d = (cnt_q == CNT_LAST) ? ST_DONE : ST_ADD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: selection, pointer, shift registers, carry, counter.
    always_comb begin
        sel_d   = sel_q;
        last_d  = last_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                sel_d = pick_vld_s ? pick_s : sel_q;
            end
            ST_LOAD: begin
                a_sh_d  = a_sel_s;
                b_sh_d  = b_sel_s;
                sum_d   = '0;
                carry_d = 1'b0;
                cnt_d   = '0;
                last_d  = sel_q;
            end
            ST_ADD: begin
                a_sh_d  = {1'b0, a_sh_q[WORDWIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WORDWIDTH-1:1]};
                sum_d   = sum_next_s;
                carry_d = c_next_s;
                cnt_d   = cnt_q + 1'b1;
            end
            ST_DONE: begin
                sel_d = sel_q;
            end
            default: begin
                sel_d = sel_q;
            end
        endcase
    end

    // Output next values, registered so each pulse lines up with its state.
    always_comb begin
        gnt_d     = (state_d == ST_LOAD) ? onehot(sel_d) : '0;
        ack_d     = (state_d == ST_DONE) ? onehot(sel_q) : '0;
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        out_d     = (state_d == ST_DONE) ? result_s : out_q;
        cout_d    = (state_d == ST_DONE) ? c_next_s : cout_q;
        done_id_d = (state_d == ST_DONE) ? sel_q    : done_id_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            last_q    <= ID_LAST;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            out_q     <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            last_q    <= last_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            out_q     <= out_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign out     = out_q;
    assign cout    = cout_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_serial_adder_rr_sched.sv
// Directed and table-driven bench for serial_adder_rr_sched (WORDWIDTH=8, NREQ=4).
module tb_serial_adder_rr_sched;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int ID = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   out;
    logic           cout;
    logic           done;
    logic [ID-1:0]  done_id;
    logic           busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_rr_sched #(.WORDWIDTH(W), .NREQ(N), .IDW(ID)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .ack(ack), .out(out), .cout(cout), .done(done),
        .done_id(done_id), .busy(busy)
    );

    typedef struct {
        int         rid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] o;
        logic [W-1:0] o_sat;
        logic       c;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [W-1:0] model_out(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef SERIAL_SCHED_SATURATE_EN
        if (s[W]) return {W{1'b1}};
`endif
        return s[W-1:0];
    endfunction

    function automatic logic model_c(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One operation from a single requester; drops req when ack is seen.
    task automatic run_op(input string nm, input int rid, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_o,
                          input logic exp_c);
        int gcyc;
        int dcyc;
        gcyc = -1;
        dcyc = -1;
        @(negedge clk);
        a_in[rid*W +: W] = a;
        b_in[rid*W +: W] = b;
        req[rid] = 1'b1;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            @(negedge clk);
            if (gnt != '0 && gcyc < 0) begin
                gcyc = c;
                chk({nm, " gnt"}, 32'(gnt), 32'(oh(rid)));
            end
            if (done) begin
                dcyc = c;
                chk({nm, " out"}, 32'(out), 32'(exp_o));
                chk({nm, " cout"}, 32'(cout), 32'(exp_c));
                chk({nm, " done_id"}, 32'(done_id), 32'(rid));
                chk({nm, " ack"}, 32'(ack), 32'(oh(rid)));
                req[rid] = 1'b0;
            end
        end
        req[rid] = 1'b0;
        chk({nm, " gnt latency"}, 32'(gcyc), 32'd1);
        chk({nm, " done latency"}, 32'(dcyc), 32'(W + 2));
    endtask

    // Wall-clock guard in case a bounded loop is ever broken.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int n_done;
        logic [W-1:0] fa [N];
        logic [W-1:0] fb [N];
        int d1;
        int d2;
        int ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int rr;

        vecs[0] = '{0, 8'd200, 8'd100, 8'd44,  8'd255, 1'b1};
        vecs[1] = '{0, 8'd255, 8'd1,   8'd0,   8'd255, 1'b1};
        vecs[2] = '{1, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0};
        vecs[3] = '{2, 8'd127, 8'd128, 8'd255, 8'd255, 1'b0};
        vecs[4] = '{3, 8'd85,  8'd170, 8'd255, 8'd255, 1'b0};
        vecs[5] = '{1, 8'd128, 8'd128, 8'd0,   8'd255, 1'b1};
        vecs[6] = '{2, 8'd3,   8'd5,   8'd8,   8'd8,   1'b0};
        vecs[7] = '{3, 8'd240, 8'd15,  8'd255, 8'd255, 1'b0};
        vecs[8] = '{0, 8'd100, 8'd200, 8'd44,  8'd255, 1'b1};

        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset out", 32'(out), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset done_id", 32'(done_id), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Table-driven single operations
        for (int i = 0; i < 9; i++) begin
`ifdef SERIAL_SCHED_SATURATE_EN
            run_op($sformatf("vec%0d", i), vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].o_sat, vecs[i].c);
`else
            run_op($sformatf("vec%0d", i), vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].c);
`endif
        end

        // Fairness: all four request at once, each drops on its ack
        do_reset();
        for (int i = 0; i < N; i++) begin
            fa[i] = W'(i * 37 + 11);
            fb[i] = W'(i * 59 + 200);
            a_in[i*W +: W] = fa[i];
            b_in[i*W +: W] = fb[i];
        end
        @(negedge clk);
        req = 4'b1111;
        n_done = 0;
        for (int c = 0; c < 100 && n_done < 4; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (gnt[k]) order.push_back(k);
                end
            end
            if (done && order.size() > n_done) begin
                rr = order[n_done];
                chk($sformatf("fair%0d done_id", n_done), 32'(done_id), 32'(rr));
                chk($sformatf("fair%0d ack", n_done), 32'(ack), 32'(oh(rr)));
                chk($sformatf("fair%0d out", n_done), 32'(out), 32'(model_out(fa[rr], fb[rr])));
                chk($sformatf("fair%0d cout", n_done), 32'(cout), 32'(model_c(fa[rr], fb[rr])));
                req = req & ~ack;
                n_done++;
            end
        end
        chk("fair ops", 32'(order.size()), 32'd4);
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            chk($sformatf("fair order%0d", k), 32'(order[k]), 32'(k));
        end
        req = '0;

        // Re-raise 1010: expect 1 then 3
        order.delete();
        @(negedge clk);
        req = 4'b1010;
        n_done = 0;
        for (int c = 0; c < 60 && n_done < 2; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (gnt[k]) order.push_back(k);
                end
            end
            if (done) begin
                req = req & ~ack;
                n_done++;
            end
        end
        chk("rr2 ops", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("rr2 first", 32'(order[0]), 32'd1);
            chk("rr2 second", 32'(order[1]), 32'd3);
        end
        req = '0;

        // Late change: operands and req altered during ADD
        @(negedge clk);
        a_in[2*W +: W] = 8'd10;
        b_in[2*W +: W] = 8'd20;
        req[2] = 1'b1;
        d1 = -1;
        for (int c = 1; c <= 5 && d1 < 0; c++) begin
            @(negedge clk);
            if (gnt != '0) d1 = c;
        end
        chk("late gnt seen", 32'(d1), 32'd1);
        repeat (2) @(negedge clk);
        a_in[2*W +: W] = 8'd99;
        b_in[2*W +: W] = 8'd77;
        req[2] = 1'b0;
        d2 = -1;
        for (int c = 1; c <= 20 && d2 < 0; c++) begin
            @(negedge clk);
            if (done) begin
                d2 = c;
                chk("late out", 32'(out), 32'd30);
                chk("late cout", 32'(cout), 32'd0);
                chk("late ack", 32'(ack), 32'(4'b0100));
                chk("late done_id", 32'(done_id), 32'd2);
            end
        end
        chk("late done seen", 32'(d2 > 0), 32'd1);

        // Reset in the 4th ADD cycle of an op from requester 0
        @(negedge clk);
        a_in[0 +: W] = 8'd50;
        b_in[0 +: W] = 8'd60;
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) chk("abort gnt", 32'(gnt), 32'(4'b0001));
            if (c == 4) chk("abort busy", 32'(busy), 32'd1);
        end
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort out", 32'(out), 32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        chk("abort done_id", 32'(done_id), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort gnt0", 32'(gnt), 32'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || ack != '0) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);
        a_in[1*W +: W] = 8'd1;
        b_in[1*W +: W] = 8'd2;
        req = 4'b0011;
        d1 = -1;
        ndone = 0;
        for (int c = 1; c <= 40 && ndone < 2; c++) begin
            @(negedge clk);
            if (gnt != '0 && d1 < 0) begin
                d1 = c;
                chk("post-reset first gnt", 32'(gnt), 32'(4'b0001));
            end
            if (done) begin
                req = req & ~ack;
                ndone++;
            end
        end
        chk("post-reset ops", 32'(ndone), 32'd2);
        req = '0;

        // Back-to-back service with req held continuously
        @(negedge clk);
        a_in[2*W +: W] = 8'd7;
        b_in[2*W +: W] = 8'd9;
        req[2] = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 60 && d2 < 0; c++) begin
            @(negedge clk);
            if (done && d1 < 0) begin
                d1 = c;
            end else if (done) begin
                d2 = c;
                req[2] = 1'b0;
                chk("b2b out", 32'(out), 32'd16);
            end
        end
        chk("b2b spacing", 32'(d2 - d1), 32'(W + 3));
        req = '0;

        // Random operands from random requesters
        for (int k = 0; k < 1000; k++) begin
            rr = $urandom_range(N - 1, 0);
            ra = W'($urandom_range(255, 0));
            rb = W'($urandom_range(255, 0));
            run_op($sformatf("rnd%0d", k), rr, ra, rb, model_out(ra, rb), model_c(ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
